tt_extractor: RTL and testbench

//   Sequential truth-table extractor: the read-back counterpart of our

---
 rtl/tt_extractor.sv | 130 +++++++++++++
 tb/tb_tt_extractor.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tt_extractor.sv
// Sequential truth-table extractor: walks every minterm of a function under test,
// samples its output after a settle window and reports the table on valid/ready.
module tt_extractor #(
   parameter int N_IN          = 4,
   parameter int SETTLE_CYCLES = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [2**N_IN-1:0]   exp_tt,
   output logic [N_IN-1:0]      x_drive,
   input  logic                 y_in,
   output logic                 busy,
   output logic [2**N_IN-1:0]   tt,
   output logic                 tt_valid,
   input  logic                 tt_ready,
   output logic                 mismatch
);

   localparam int TT_W = 2**N_IN;
   localparam int SW   = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [N_IN-1:0] IDX_LAST   = '1;
   localparam logic [SW-1:0]   SETTLE_END = SW'(SETTLE_CYCLES);

   logic [1:0]      state_q,    state_d;
   logic [N_IN-1:0] idx_q,      idx_d;
   logic [SW-1:0]   settle_q,   settle_d;
   logic [TT_W-1:0] exp_q,      exp_d;
   logic [TT_W-1:0] tt_q,       tt_d;
   logic [N_IN-1:0] x_drive_q,  x_drive_d;
   logic            busy_q,     busy_d;
   logic            tt_valid_q, tt_valid_d;
   logic            mismatch_q, mismatch_d;

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      settle_d   = settle_q;
      exp_d      = exp_q;
      tt_d       = tt_q;
      x_drive_d  = x_drive_q;
      busy_d     = busy_q;
      tt_valid_d = tt_valid_q;
      mismatch_d = mismatch_q;

      case (state_q)
         S_IDLE: begin
            x_drive_d = '0;
            if (start) begin
               exp_d     = exp_tt;
               idx_d     = '0;
               settle_d  = '0;
               tt_d      = '0;
               busy_d    = 1'b1;
               state_d   = S_RUN;
            end
         end
         S_RUN: begin
            if (settle_q == SETTLE_END) begin
               tt_d[idx_q] = y_in;
               settle_d    = '0;
               if (idx_q == IDX_LAST) begin
                  // mismatch uses the table including the bit sampled on this edge
                  state_d    = S_DONE;
                  x_drive_d  = '0;
                  tt_valid_d = 1'b1;
                  mismatch_d = (tt_d != exp_q);
               end else begin
                  idx_d     = idx_q + N_IN'(1);
                  x_drive_d = idx_q + N_IN'(1);
               end
            end else begin
               settle_d = settle_q + SW'(1);
            end
         end
         S_DONE: begin
            x_drive_d = '0;
            if (tt_valid_q && tt_ready) begin
               tt_valid_d = 1'b0;
               mismatch_d = 1'b0;
               busy_d     = 1'b0;
               state_d    = S_IDLE;
            end
         end
         default: begin
            state_d    = S_IDLE;
            x_drive_d  = '0;
            busy_d     = 1'b0;
            tt_valid_d = 1'b0;
            mismatch_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         idx_q      <= '0;
         settle_q   <= '0;
         exp_q      <= '0;
         tt_q       <= '0;
         x_drive_q  <= '0;
         busy_q     <= 1'b0;
         tt_valid_q <= 1'b0;
         mismatch_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         settle_q   <= settle_d;
         exp_q      <= exp_d;
         tt_q       <= tt_d;
         x_drive_q  <= x_drive_d;
         busy_q     <= busy_d;
         tt_valid_q <= tt_valid_d;
         mismatch_q <= mismatch_d;
      end
   end

   assign x_drive  = x_drive_q;
   assign busy     = busy_q;
   assign tt       = tt_q;
   assign tt_valid = tt_valid_q;
   assign mismatch = mismatch_q;

endmodule

// File: tb/tb_tt_extractor.sv
// Bench for tt_extractor: three instances (default, SETTLE_CYCLES=3, N_IN=2) checked
// against a cycle-count/truth-table model plus hand-computed literal expectations.
module tb_tt_extractor;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start_r;
   logic [15:0] exp_tt;
   logic        tt_ready;
   int          inst;
   int          fut_sel;
   int          cur_w;
   int          cur_s;
   int          errors = 0;
   int          checks = 0;

   always #5 clk = ~clk;

   function automatic logic fut(input int sel, input int m);
      logic [5:0] x;
      x = m[5:0];
      case (sel)
         0:       return x[0] & x[1];
         1:       return (x[0] & x[1]) | (x[0] & x[2]) | (x[1] & x[2]);
         2:       return x[3];
         3:       return ~x[0];
         default: return x[0] ^ x[1];
      endcase
   endfunction

   function automatic logic [63:0] model_tt(input int sel, input int w);
      logic [63:0] t;
      t = '0;
      for (int i = 0; i < w; i++) t[i] = fut(sel, i);
      return t;
   endfunction

   function automatic logic [63:0] wmask(input int w);
      if (w >= 64) return '1;
      return (64'd1 << w) - 64'd1;
   endfunction

   // DUT instances
   logic [3:0]  x0, x1;
   logic [1:0]  x2;
   logic [15:0] t0, t1;
   logic [3:0]  t2;
   logic        b0, b1, b2, v0, v1, v2, m0, m1, m2;

   tt_extractor u_dut (
      .clk(clk), .rst_n(rst_n), .start(start_r && inst == 0), .exp_tt(exp_tt),
      .x_drive(x0), .y_in(fut(fut_sel, int'(x0))), .busy(b0), .tt(t0),
      .tt_valid(v0), .tt_ready(tt_ready), .mismatch(m0));

   tt_extractor #(.N_IN(4), .SETTLE_CYCLES(3)) u_dut_s3 (
      .clk(clk), .rst_n(rst_n), .start(start_r && inst == 1), .exp_tt(exp_tt),
      .x_drive(x1), .y_in(fut(fut_sel, int'(x1))), .busy(b1), .tt(t1),
      .tt_valid(v1), .tt_ready(tt_ready), .mismatch(m1));

   tt_extractor #(.N_IN(2), .SETTLE_CYCLES(1)) u_dut_n2 (
      .clk(clk), .rst_n(rst_n), .start(start_r && inst == 2), .exp_tt(exp_tt[3:0]),
      .x_drive(x2), .y_in(fut(fut_sel, int'(x2))), .busy(b2), .tt(t2),
      .tt_valid(v2), .tt_ready(tt_ready), .mismatch(m2));

   logic [3:0]  obs_x;
   logic [15:0] obs_tt;
   logic        obs_busy, obs_valid, obs_mm;

   always_comb begin
      case (inst)
         1: begin
            obs_x = x1; obs_tt = t1; obs_busy = b1; obs_valid = v1; obs_mm = m1;
         end
         2: begin
            obs_x = {2'b00, x2}; obs_tt = {12'h000, t2};
            obs_busy = b2; obs_valid = v2; obs_mm = m2;
         end
         default: begin
            obs_x = x0; obs_tt = t0; obs_busy = b0; obs_valid = v0; obs_mm = m0;
         end
      endcase
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: a run lasts cur_w*(cur_s+1) cycles after acceptance, then the table is offered
   logic        m_busy, m_valid, m_mm;
   logic [63:0] m_tt, m_exp;
   int          m_cyc;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy <= 1'b0; m_valid <= 1'b0; m_mm <= 1'b0;
         m_tt <= '0; m_exp <= '0; m_cyc <= 0;
      end else if (!m_busy) begin
         if (start_r) begin
            m_busy <= 1'b1;
            m_cyc  <= 1;
            m_exp  <= 64'(exp_tt) & wmask(cur_w);
         end
      end else if (m_valid) begin
         if (tt_ready) begin
            m_valid <= 1'b0;
            m_busy  <= 1'b0;
         end
      end else begin
         m_cyc <= m_cyc + 1;
         if (m_cyc + 1 == cur_w * (cur_s + 1) + 1) begin
            m_valid <= 1'b1;
            m_tt    <= model_tt(fut_sel, cur_w);
            m_mm    <= (model_tt(fut_sel, cur_w) != m_exp);
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         chk("x_drive", 64'(obs_x),
             (m_busy && !m_valid) ? 64'((m_cyc - 1) / (cur_s + 1)) : 64'd0);
         chk("busy", 64'(obs_busy), 64'(m_busy));
         chk("tt_valid", 64'(obs_valid), 64'(m_valid));
         if (m_valid) begin
            chk("tt", 64'(obs_tt), m_tt);
            chk("mismatch", 64'(obs_mm), 64'(m_mm));
         end else if (!m_busy) begin
            chk("tt_idle", 64'(obs_tt), m_tt);
         end
      end
   end

   task automatic reset_to(input int k);
      @(negedge clk);
      rst_n = 1'b0;
      inst  = k;
      cur_w = (k == 2) ? 4 : 16;
      cur_s = (k == 1) ? 3 : 1;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic do_start(input logic [15:0] e);
      @(negedge clk);
      exp_tt  = e;
      start_r = 1'b1;
      @(negedge clk);
      start_r = 1'b0;
      exp_tt  = ~e;
   endtask

   task automatic wait_valid(input int pulse_at, output int lat);
      int cyc;
      cyc = 1;
      while (!obs_valid && cyc < 400) begin
         @(negedge clk);
         cyc++;
         start_r = (cyc == pulse_at);
      end
      start_r = 1'b0;
      if (!obs_valid) chk("valid_timeout", 64'd0, 64'd1);
      lat = cyc;
   endtask

   initial begin
      int lat;
      rst_n = 1'b0; start_r = 1'b0; exp_tt = '0; tt_ready = 1'b1;
      inst = 0; fut_sel = 0; cur_w = 16; cur_s = 1;
      #12;
      chk("rst_x", 64'(obs_x), 64'd0);
      chk("rst_busy", 64'(obs_busy), 64'd0);
      chk("rst_valid", 64'(obs_valid), 64'd0);
      chk("rst_tt", 64'(obs_tt), 64'd0);
      chk("rst_mm", 64'(obs_mm), 64'd0);

      // 1: AND, matching expectation
      reset_to(0);
      fut_sel = 0;
      do_start(16'h8888);
      wait_valid(0, lat);
      chk("t1_latency", 64'(lat), 64'd33);
      chk("t1_tt", 64'(obs_tt), 64'h8888);
      chk("t1_mm", 64'(obs_mm), 64'd0);
      @(negedge clk);
      chk("t1_valid_1cyc", 64'(obs_valid), 64'd0);
      chk("t1_busy_off", 64'(obs_busy), 64'd0);

      // 2: majority, one-bit expectation difference
      fut_sel = 1;
      do_start(16'hE8E9);
      wait_valid(0, lat);
      chk("t2_tt", 64'(obs_tt), 64'hE8E8);
      chk("t2_mm", 64'(obs_mm), 64'd1);
      @(negedge clk);

      // 3: longer settle window
      reset_to(1);
      fut_sel = 2;
      do_start(16'hFF00);
      wait_valid(0, lat);
      chk("t3_latency", 64'(lat), 64'd65);
      chk("t3_tt", 64'(obs_tt), 64'hFF00);
      @(negedge clk);

      // 4: backpressure with start pulses, then start coincident with the handshake
      reset_to(0);
      fut_sel  = 0;
      tt_ready = 1'b0;
      do_start(16'h8888);
      wait_valid(0, lat);
      for (int k = 0; k < 10; k++) begin
         start_r = (k % 2 == 1);
         @(negedge clk);
         chk("t4_hold_valid", 64'(obs_valid), 64'd1);
         chk("t4_hold_tt", 64'(obs_tt), 64'h8888);
      end
      tt_ready = 1'b1;
      start_r  = 1'b1;
      @(negedge clk);
      start_r  = 1'b0;
      chk("t4_hs_valid", 64'(obs_valid), 64'd0);
      chk("t4_hs_busy", 64'(obs_busy), 64'd0);
      @(negedge clk);
      chk("t4_no_requeue", 64'(obs_busy), 64'd0);

      // 5: asynchronous abort mid-run, then a clean run
      reset_to(0);
      fut_sel = 3;
      do_start(16'h5555);
      repeat (11) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_abort_x", 64'(obs_x), 64'd0);
      chk("t5_abort_busy", 64'(obs_busy), 64'd0);
      chk("t5_abort_valid", 64'(obs_valid), 64'd0);
      chk("t5_abort_tt", 64'(obs_tt), 64'd0);
      chk("t5_abort_mm", 64'(obs_mm), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      do_start(16'h5555);
      wait_valid(0, lat);
      chk("t5_tt", 64'(obs_tt), 64'h5555);
      chk("t5_mm", 64'(obs_mm), 64'd0);
      @(negedge clk);

      // 6: two inputs, start pulsed while running
      reset_to(2);
      fut_sel = 4;
      do_start(16'h0006);
      wait_valid(3, lat);
      chk("t6_latency", 64'(lat), 64'd9);
      chk("t6_tt", 64'(obs_tt), 64'h6);
      chk("t6_mm", 64'(obs_mm), 64'd0);
      repeat (2) @(negedge clk);
      chk("t6_idle", 64'(obs_busy), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
